// File: rtl/exec_seq.sv
// exec_seq: 6502 execute-stage sequencer. Owns A and P, drives an external
// binary-only ALU, and performs decimal ADC/SBC as three binary ADD passes.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE, out of reset, and
// when no direct accumulator load is pending. Once accepted, op/operand/D
// are latched and the request inputs are free to change. done pulses for
// one cycle after the final capture, and req_ready is high again in that
// same cycle.
module exec_seq #(
    parameter logic [7:0] P_RESET = 8'h24,
    parameter logic [2:0] ALU_ADD = 3'd0,
    parameter logic [2:0] ALU_AND = 3'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_operand,
    input  logic       acc_wr_en,
    input  logic [7:0] acc_wr_data,
    output logic [2:0] alu_ctrl,
    output logic [7:0] alu_AI,
    output logic [7:0] alu_BI,
    output logic       alu_carry,
    output logic       alu_BCD,
    input  logic [7:0] alu_Y,
    input  logic [7:0] alu_flags,
    output logic [7:0] acc,
    output logic [7:0] p_reg,
    output logic       done,
    output logic [1:0] dbg_state
);

    localparam logic [2:0] OP_ADC = 3'd0;
    localparam logic [2:0] OP_SBC = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_CMP = 3'd3;
    localparam logic [2:0] OP_CLC = 3'd4;
    localparam logic [2:0] OP_SEC = 3'd5;
    localparam logic [2:0] OP_CLD = 3'd6;
    localparam logic [2:0] OP_SED = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_ADJ_LO = 2'd2,
        S_ADJ_HI = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_a;
    logic [7:0] r_p;
    logic [2:0] r_op;
    logic [7:0] r_m;
    logic       r_dec;
    logic [7:0] r_t;      // decimal intermediate: T after pass 1, T2 after pass 2
    logic       r_c1;
    logic       r_c2;
    logic       r_h;
    logic       r_done;

    logic [2:0] w_ctrl;
    logic [7:0] w_ai;
    logic [7:0] w_bi;
    logic       w_cin;
    logic       w_is_dec;
    logic       w_v;
    logic       w_h;
    logic       w_y_zero;
    logic       w_unused;

    // Only C, Z and N are ever taken from the ALU flag bus.
    assign w_unused = &{1'b0, alu_flags[6:2]};

    assign w_is_dec = r_dec & ((r_op == OP_ADC) | (r_op == OP_SBC));
    assign w_v      = (w_ai[7] == w_bi[7]) & (alu_Y[7] != w_ai[7]);
    assign w_h      = alu_Y[4] ^ w_ai[4] ^ w_bi[4];
    assign w_y_zero = (alu_Y == 8'h00);

    assign req_ready = rst_n & (r_state == S_IDLE) & ~acc_wr_en;
    assign alu_ctrl  = w_ctrl;
    assign alu_AI    = w_ai;
    assign alu_BI    = w_bi;
    assign alu_carry = w_cin;
    assign alu_BCD   = 1'b0;
    assign acc       = r_a;
    assign p_reg     = r_p;
    assign done      = r_done;
    assign dbg_state = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and ALU drive; idle drive is the default in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = ALU_ADD;
        w_ai        = 8'h00;
        w_bi        = 8'h00;
        w_cin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && !acc_wr_en) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (r_op)
                    OP_ADC: begin w_ai = r_a; w_bi = r_m;  w_cin = r_p[0]; end
                    OP_SBC: begin w_ai = r_a; w_bi = ~r_m; w_cin = r_p[0]; end
                    OP_CMP: begin w_ai = r_a; w_bi = ~r_m; w_cin = 1'b1;   end
                    OP_AND: begin w_ctrl = ALU_AND; w_ai = r_a; w_bi = r_m; end
                    default: ;
                endcase
                w_state_nxt = w_is_dec ? S_ADJ_LO : S_IDLE;
            end
            S_ADJ_LO: begin
                w_ai = r_t;
                if (r_op == OP_ADC) w_bi = ((r_t[3:0] > 4'd9) || r_h) ? 8'h06 : 8'h00;
                else                w_bi = (!r_h) ? 8'hFA : 8'h00;
                w_state_nxt = S_ADJ_HI;
            end
            S_ADJ_HI: begin
                w_ai = r_t;
                if (r_op == OP_ADC) w_bi = ((r_t[7:4] > 4'd9) || r_c1 || r_c2) ? 8'h60 : 8'h00;
                else                w_bi = (!r_c1) ? 8'hA0 : 8'h00;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: request latch, direct A load, and per-pass capture into A/P.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= 8'h00;
            r_p    <= P_RESET;
            r_op   <= OP_ADC;
            r_m    <= 8'h00;
            r_dec  <= 1'b0;
            r_t    <= 8'h00;
            r_c1   <= 1'b0;
            r_c2   <= 1'b0;
            r_h    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (acc_wr_en) begin
                        r_a    <= acc_wr_data;
                        r_p[7] <= acc_wr_data[7];
                        r_p[1] <= (acc_wr_data == 8'h00);
                    end else if (req_valid) begin
                        r_op  <= req_op;
                        r_m   <= req_operand;
                        r_dec <= r_p[3];
                    end
                end
                S_EXEC: begin
                    r_done <= ~w_is_dec;
                    case (r_op)
                        OP_ADC, OP_SBC: begin
                            // N, V, Z come from the binary sum in both modes.
                            r_p[7] <= alu_Y[7];
                            r_p[6] <= w_v;
                            r_p[1] <= w_y_zero;
                            if (w_is_dec) begin
                                r_t  <= alu_Y;
                                r_c1 <= alu_flags[0];
                                r_h  <= w_h;
                            end else begin
                                r_a    <= alu_Y;
                                r_p[0] <= alu_flags[0];
                            end
                        end
                        OP_CMP: begin
                            r_p[7] <= alu_Y[7];
                            r_p[1] <= w_y_zero;
                            r_p[0] <= alu_flags[0];
                        end
                        OP_AND: begin
                            r_a    <= alu_Y;
                            r_p[7] <= alu_flags[7];
                            r_p[1] <= alu_flags[1];
                        end
                        OP_CLC: r_p[0] <= 1'b0;
                        OP_SEC: r_p[0] <= 1'b1;
                        OP_CLD: r_p[3] <= 1'b0;
                        OP_SED: r_p[3] <= 1'b1;
                        default: ;
                    endcase
                end
                S_ADJ_LO: begin
                    r_t  <= alu_Y;
                    r_c2 <= alu_flags[0];
                end
                S_ADJ_HI: begin
                    r_a    <= alu_Y;
                    r_p[0] <= (r_op == OP_ADC) ? (r_c1 | r_c2 | alu_flags[0]) : r_c1;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/exec_seq.md
# exec_seq

Execute-stage sequencer that drives the 6502 ALU and owns the accumulator (A) and processor status (P) registers. It accepts one operation at a time over a valid/ready handshake and drives the ALU's control and operand inputs. It captures `alu_Y` and the flags into A/P and signals completion. Decimal-mode ADC/SBC is done as a fixed three-pass sequence with `alu_BCD` held low. Each pass is a binary ADD, so the ALU never needs BCD support.

## Interface
- `P_RESET`, 8'h24: P value after reset (I and bit 5 set).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: operation request valid.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 3: 0 ADC, 1 SBC, 2 AND, 3 CMP, 4 CLC, 5 SEC, 6 CLD, 7 SED.
- `req_operand` in 8: memory operand M; ignored for ops 4-7.
- `acc_wr_en` in 1: direct accumulator load (LDA path).
- `acc_wr_data` in 8: accumulator load value.
- `alu_ctrl` out 3: ALU opcode, using the `ADD`/`AND` encodings from params.vh.
- `alu_AI` out 8: ALU operand A.
- `alu_BI` out 8: ALU operand B.
- `alu_carry` out 1: ALU carry in.
- `alu_BCD` out 1: always 0.
- `alu_Y` in 8: ALU result.
- `alu_flags` in 8: ALU flags, bit positions as P.
- `acc` out 8: accumulator.
- `p_reg` out 8: status register; N=7, V=6, D=3, Z=1, C=0.
- `done` out 1: one-cycle pulse; `acc`/`p_reg` already hold the final result.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - EXEC: pass 1.
  - ADJ_LO: decimal pass 2.
  - ADJ_HI: decimal pass 3.
- Transitions:
  - Accept on `req_valid && req_ready` at a rising edge: latch op, operand and D; IDLE→EXEC.
  - From EXEC: binary ops and ops 2-7 capture results and return to IDLE. ADC/SBC with D=1 go EXEC→ADJ_LO→ADJ_HI→IDLE.
- Idle ALU drive: `alu_ctrl`=ADD, AI=BI=0, `alu_carry`=0.
- EXEC drive for ADC: AI=A, BI=M, carry=C.
- EXEC drive for SBC and CMP: BI=~M. Carry is C for SBC and 1 for CMP.
- EXEC drive for AND: `alu_ctrl`=AND, AI=A, BI=M.
- Flag sourcing:
  - C is taken from `alu_flags[0]` after ADD.
  - Z and N are taken from `alu_flags[1]` and `alu_flags[7]` after AND.
  - Z and N after ADD are computed locally from `alu_Y`.
  - V = (AI[7]==BI[7]) && (Y[7]!=AI[7]).
  - No other ALU flag bits are sampled.
- Binary ADC/SBC: A←Y. N, V, Z and C update.
- CMP: A unchanged. N, Z and C update; V unchanged.
- AND: A←Y. N and Z update; V and C unchanged.
- Ops 4-7: clear or set C or D only. They still take one EXEC cycle, and the ALU is driven with idle values.
- Decimal pass 1: binary sum T, carry c1, half-carry h = T[4]^AI[4]^BI[4]. N, V and Z come from T and are final.
- ADJ_LO (AI=T, carry 0):
  - ADC: BI=06 if T[3:0]>9 or h, else 00. Gives T2 and carry c2.
  - SBC: BI=FA if !h, else 00.
- ADJ_HI (AI=T2, carry 0):
  - ADC: BI=60 if T2[7:4]>9 or c1 or c2, else 00. Gives carry c3.
  - SBC: BI=A0 if !c1, else 00.
  - A←Y.
- Decimal C result: ADC C = c1|c2|c3; SBC C = c1.
- Adjust passes always run, even when the correction is 00.
- `acc_wr_en` in IDLE:
  - It has priority over a request: `req_ready` is 0 in that cycle.
  - A←`acc_wr_data` and N/Z are updated.
  - `done` is not pulsed.
- `acc_wr_en` outside IDLE is ignored.
- P bits 2, 4 and 5 are written only by reset.

## Timing
- Reset values: `acc`=00, `p_reg`=`P_RESET`, `done`=0, `req_ready`=0, ALU outputs at idle drive.
- `req_ready`=1 in the first cycle after `rst_n` rises.
- Binary and flag ops: accept at edge E0, EXEC during cycle E0-E1, capture at E1. `done`=1 in the cycle after E1.
- Decimal ADC/SBC: capture at E3; `done` in the cycle after E3.
- `req_ready` is back to 1 in the `done` cycle, so a new request can be accepted at the edge ending that cycle. Throughput is one binary op every 2 cycles.
- `req_operand` is sampled only at acceptance and may change afterward.
- `rst_n` low mid-operation: the operation is abandoned at that edge, no `done`, and all registers take their reset values.

## Test plan
- Reset: hold `rst_n` low 2 cycles, release → `acc`=00, `p_reg`=24, `done`=0, `req_ready`=1 next cycle.
- Binary ADC: load A=50, CLC, ADC 50 → A=A0, N=1, V=1, Z=0, C=0. `done` 2 cycles after accept.
- Decimal ADC: SED, CLC, A=58, ADC 46 → A=04, C=1. `done` 4 cycles after accept.
- Decimal SBC: SED, SEC, A=42, SBC 13 → A=29, C=1. With C=1 and A=10, SBC 20 → A=90, C=0.
- CMP and AND:
  - A=10, CMP 20 → A=10, C=0, N=1, Z=0.
  - A=F0, AND 0F → A=00, Z=1, N=0, C unchanged.
- Back-to-back and reset:
  - Hold `req_valid` for two ADCs → second accepted in the first `done` cycle.
  - Assert `rst_n`=0 during ADJ_LO → no `done`; A=00, P=24.
